// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b mod 2^WIDTH and borrow = (a < b), one bit per cycle, LSB first.
// Latency is WIDTH cycles from start to done; there is no backpressure, and start is ignored while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] p_q, p_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    logic             bit_d;
    logic             bit_bout;
    logic             last_bit;

    assign bit_d    = a_q[0] ^ b_q[0] ^ bin_q;
    assign bit_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Partial result only needs WIDTH-1 bits; the final bit goes straight into diff.
                p_d   = (WIDTH-1)'({bit_d, p_q} >> 1);
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = bit_bout;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d  = IDLE;
                    diff_d   = {bit_d, p_q};
                    borrow_d = bit_bout;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result bit width; legal range 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request a subtraction; sampled only when the block is idle.
REQ-005 The module SHALL have port a, input, WIDTH bits: minuend, captured on an accepted start.
REQ-006 The module SHALL have port b, input, WIDTH bits: subtrahend, captured on an accepted start.
REQ-007 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The module SHALL have port diff, output, WIDTH bits: registered result a-b, modulo 2^WIDTH.
REQ-010 The module SHALL have port borrow, output, 1 bit: registered final borrow-out, set when a < b unsigned.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and SHIFT, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture a and b into internal shift registers, clear the internal borrow flop and the counter, and enter SHIFT; busy SHALL be 1 from that edge.
REQ-013 In IDLE with start=0, the block SHALL hold all registers.
REQ-014 Each SHIFT cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin); d shifts into the partial-result register from the MSB end, operand registers shift right, and bout is stored as the next bin.
REQ-015 SHIFT SHALL last exactly WIDTH cycles; at the edge that processes bit WIDTH-1, the FSM SHALL return to IDLE, load diff from the completed partial result, load borrow from that bit's bout, clear busy, and set done.
REQ-016 done SHALL be high for exactly one cycle, the first IDLE cycle after completion, and SHALL be 0 otherwise.
REQ-017 Latency SHALL be fixed: start accepted at edge k gives done=1 and valid diff/borrow after edge k+WIDTH, independent of operand values.
REQ-018 start while busy=1 SHALL be ignored: no recapture of a or b, no restart, and no effect on the result.
REQ-019 start=1 during the done cycle SHALL be accepted as a normal IDLE start, giving back-to-back operations with no dead cycle.
REQ-020 diff and borrow SHALL change only at completion edges (REQ-015); they SHALL hold their last result through IDLE and through the whole of a following operation.
REQ-021 a and b SHALL be don't-care except at the accepting edge.

Reset
REQ-022 While rst_n=0, the block SHALL force state IDLE, counter 0, all operand and partial registers 0, and busy=0, done=0, diff=0, borrow=0, without waiting for a clock edge.
REQ-023 Reset asserted mid-operation SHALL abandon the operation with no done pulse; after release the block SHALL be in IDLE and accept start on the first rising edge with rst_n=1.

Verification
REQ-024 Basic, WIDTH=8: a=0x5A, b=0x3C, start for 1 cycle -> busy for 8 cycles, then done pulse; diff=0x1E, borrow=0.
REQ-025 Underflow: a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0xFF, b=0xFF -> diff=0x00, borrow=0; a=0x80, b=0x7F -> diff=0x01, borrow=0.
REQ-026 Start while busy: start a=0x10, b=0x01; 3 cycles later pulse start with a=0xAA, b=0x55 -> single done at start+8 with diff=0x0F, borrow=0; no second done follows.
REQ-027 Back-to-back: hold start=1 continuously with a=0x03, b=0x05 -> done every 9 cycles, diff=0xFE, borrow=1 each time; busy low only in done cycles.
REQ-028 Reset mid-op: start a=0x33, b=0x11; assert rst_n=0 asynchronously after 4 cycles -> outputs go to 0 immediately with no done; after release, start a=0x33, b=0x11 -> diff=0x22, borrow=0 after 8 cycles.
REQ-029 Exhaustive, WIDTH=4: all 256 (a, b) pairs back-to-back -> every result matches (a-b) mod 16 with borrow=(a<b), and every result has 4-cycle latency.
